imem_loader: RTL and testbench

//  Write-side companion of the instruction memory. The datapath only reads words at readAddress.

---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/imem_loader_byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Brief    : Shared types and constants for the instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  // Loader FSM states; CHK is only reachable when the checksum option is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

  // Byte address of a word index (word index * 4)
  function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer
//  Brief    : Packs a byte stream big-endian into 32-bit words. The fourth
//             byte completes the word combinationally, so only the first
//             three bytes of a word need to be stored.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_full_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]                       cnt_q;
  logic [BYTE_W*(WORD_BYTES-1)-1:0] sr_q;

  // Byte position counter and history of the bytes already received
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
    end else if (push_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {sr_q[BYTE_W*(WORD_BYTES-2)-1:0], byte_i};
    end
  end

  // Word completes on the push of the fourth byte
  always_comb begin
    word_full_o = push_i && (cnt_q == 2'd3);
    word_o      = {sr_q, byte_i};
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Loads a length-prefixed byte stream into the instruction memory
//             as 32-bit big-endian words at byte addresses 0,4,8,... and holds
//             the CPU until the program is complete.
//  Options  : LOADER_CHECKSUM_EN - adds a trailing XOR checksum byte (CHK).
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 16
) (
  input  logic              clkFase,
  input  logic              rstFase,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [31:0]       wAddress,
  output logic [WORD_W-1:0] wData,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  len_hi_q;
  logic [LEN_W-1:0]   count_q;
  logic [LEN_W-1:0]   idx_q;
  logic               we_q;
  logic [31:0]        waddr_q;
  logic [WORD_W-1:0]  wdata_q;

  logic               start_load;
  logic               pack_push;
  logic               word_full;
  logic [WORD_W-1:0]  packed_word;
  logic [LEN_W-1:0]   len_word;
  logic               last_word;

  // start is honoured only when no load is in progress
  assign start_load = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign pack_push  = rx_valid && (state_q == DATA);
  // Length header is two bytes, high byte first
  assign len_word   = LEN_W'({len_hi_q, rx_data});
  assign last_word  = ((idx_q + LEN_W'(1)) == count_q);

  byte_packer u_packer (
    .clk_i       (clkFase),
    .rst_i       (rstFase),
    .clr_i       (start_load),
    .push_i      (pack_push),
    .byte_i      (rx_data),
    .word_full_o (word_full),
    .word_o      (packed_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;

  // Running XOR over every data byte of the current load
  always_ff @(posedge clkFase) begin
    if (rstFase || start_load) begin
      csum_q <= '0;
    end else if (pack_push) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clkFase) begin
    if (rstFase) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_word == '0)                         state_d = DONE;
          else if (len_word > LEN_W'(DEPTH_WORDS))    state_d = ERR;
          else                                        state_d = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
`else
        state_d = ERR;
`endif
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_d = LEN_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // Length/index bookkeeping and the registered write port
  always_ff @(posedge clkFase) begin
    if (rstFase) begin
      len_hi_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      // Strobe lands in the WRITE cycle, one cycle after the 4th byte
      we_q <= word_full;
      if (start_load) begin
        count_q <= '0;
        idx_q   <= '0;
      end
      if ((state_q == LEN_HI) && rx_valid) len_hi_q <= rx_data;
      if ((state_q == LEN_LO) && rx_valid) count_q  <= len_word;
      if (word_full) begin
        waddr_q <= word_byte_addr(30'(idx_q));
        wdata_q <= packed_word;
      end
      if (state_q == WRITE) idx_q <= idx_q + LEN_W'(1);
    end
  end

  assign we       = we_q;
  assign wAddress = waddr_q;
  assign wData    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Brief    : Self-checking bench for imem_loader. Programs are built as byte
//             lists; the expected memory image is derived from the list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int DEPTH = 64;

  logic        clkFase = 1'b0;
  logic        rstFase;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] wAddress;
  logic [31:0] wData;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] wq[$];    // captured writes {addr, data}
  logic [7:0]  prog[$];  // program byte stream: header + data

  imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(16)) dut (
    .clkFase  (clkFase),
    .rstFase  (rstFase),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .wAddress (wAddress),
    .wData    (wData),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clkFase = ~clkFase;

  // Record every write strobe as the memory would see it
  always @(negedge clkFase) begin
    if (we === 1'b1) wq.push_back({wAddress, wData});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one byte until it is taken; called and returns on a negedge
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit took = 1'b0;
    for (int n = 0; n < 100 && !took; n++) begin
      rx_data  = b;
      rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      took     = rx_valid && rx_ready;
      @(negedge clkFase);
    end
    rx_valid = 1'b0;
    if (!took) check_eq("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clkFase);
    start = 1'b0;
  endtask

  // Full load of prog[], then compare status and memory image with the model
  task automatic run_load(input bit gaps, input bit bad_csum, input bit poke_start);
    int          cnt;
    int          n_exp;
    bit          exp_err;
    logic [7:0]  x;
    logic [31:0] exp_word;
    wq.delete();
    pulse_start();
    check_eq("start_done_clr", {31'd0, done}, 32'd0);
    check_eq("start_err_clr", {31'd0, error}, 32'd0);
    check_eq("start_hold", {31'd0, cpu_hold}, 32'd1);
    cnt = {prog[0], prog[1]};
    send_byte(prog[0], gaps);
    send_byte(prog[1], gaps);
    x = 8'h00;
    if (cnt != 0 && cnt <= DEPTH) begin
      for (int i = 0; i < 4 * cnt; i++) begin
        send_byte(prog[2 + i], gaps);
        x = x ^ prog[2 + i];
        if (poke_start && i == 1) pulse_start();
      end
      if (CSUM_EN) send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
    end
    exp_err = (cnt > DEPTH) || (CSUM_EN && bad_csum && cnt != 0);
    n_exp   = (cnt <= DEPTH) ? cnt : 0;
    for (int k = 0; k < 20 && !(done || error); k++) @(negedge clkFase);
    repeat (3) @(negedge clkFase);
    check_eq("done", {31'd0, done}, {31'd0, !exp_err});
    check_eq("error", {31'd0, error}, {31'd0, exp_err});
    check_eq("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
    check_eq("rx_ready_end", {31'd0, rx_ready}, 32'd0);
    check_eq("n_writes", wq.size(), n_exp);
    for (int i = 0; i < n_exp && i < wq.size(); i++) begin
      exp_word = {prog[2 + 4*i], prog[3 + 4*i], prog[4 + 4*i], prog[5 + 4*i]};
      check_eq($sformatf("addr[%0d]", i), wq[i][63:32], 32'(4 * i));
      check_eq($sformatf("data[%0d]", i), wq[i][31:0], exp_word);
    end
  endtask

  task automatic make_random_prog(input int cnt);
    prog.delete();
    prog.push_back(8'(cnt >> 8));
    prog.push_back(8'(cnt));
    for (int i = 0; i < 4 * cnt; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    rstFase  = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clkFase);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_eq("rst_we", {31'd0, we}, 32'd0);
    check_eq("rst_wAddress", wAddress, 32'd0);
    check_eq("rst_wData", wData, 32'd0);
    check_eq("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    rstFase = 1'b0;
    @(negedge clkFase);

    // Reset in the middle of a word
    wq.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rstFase = 1'b1;
    @(negedge clkFase);
    check_eq("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_eq("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_we", {31'd0, we}, 32'd0);
    rstFase = 1'b0;
    @(negedge clkFase);
    check_eq("midrst_writes", wq.size(), 32'd0);

    // Known two-word program
    prog = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h10, 8'h00, 8'h04};
    run_load(1'b0, 1'b0, 1'b0);

    // Empty program and oversize header
    prog = '{8'h00, 8'h00};
    run_load(1'b0, 1'b0, 1'b0);
    prog = '{8'h00, 8'h41};
    run_load(1'b0, 1'b0, 1'b0);

    // Three words with a stuttering source
    make_random_prog(3);
    run_load(1'b1, 1'b0, 1'b0);

    // start during DATA is ignored; the load also starts from DONE
    make_random_prog(2);
    run_load(1'b0, 1'b0, 1'b1);

    // Random lengths, random gaps
    for (int t = 0; t < 4; t++) begin
      make_random_prog(int'($urandom_range(1, 6)));
      run_load(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Full-capacity program
    make_random_prog(DEPTH);
    run_load(1'b1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    prog = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1'b0, 1'b0, 1'b0);
    run_load(1'b0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
